// File: rtl/burst_grant_arb_pkg.sv
// burst_grant_arb_pkg: shared state type, default sizes and one-hot helper for the burst-grant arbiter.
package burst_grant_arb_pkg;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_CNT_W   = 3;
   localparam int MAX_REQ     = 8;
   typedef enum logic {IDLE, BURST} state_e;
   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
      return MAX_REQ'(1) << id;
   endfunction
endpackage

// File: rtl/burst_rr_pick.sv
// burst_rr_pick: combinational round-robin picker returning the first eligible index at or after ptr, wrapping.
module burst_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid,
   output logic [ID_W-1:0]    winner
);
   logic [ID_W-1:0] idx;
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (elig[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end
endmodule

// File: rtl/burst_grant_arb.sv
// burst_grant_arb: round-robin arbiter issuing fixed-length gnt bursts with a last marker and sticky protocol checking.
module burst_grant_arb
   import burst_grant_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] num_grants,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [NUM_REQ-1:0]       last,
   output logic                     busy,
   output logic [ID_W-1:0]          owner,
   output logic                     err
);
   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_id;
   logic [CNT_W-1:0]   rem_q, rem_d, cnt;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, last_q, last_d, mask_q, mask_d, chk_q, chk_d, win_oh, own_oh;
   logic               busy_q, busy_d, err_q, err_d, pick_vld;

   burst_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .elig   (req & ~mask_q),
      .ptr    (rr_ptr_q),
      .valid  (pick_vld),
      .winner (pick_id)
   );

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_id == ID_W'(i)) cnt = num_grants[i*CNT_W +: CNT_W];
      win_oh   = NUM_REQ'(onehot(3'(pick_id)));
      own_oh   = NUM_REQ'(onehot(3'(owner_q)));
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      rem_d    = rem_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      busy_d   = busy_q;
      mask_d   = '0;
      // mask_q ages into chk_q so the finished owner's req is checked two edges after its last beat
      chk_d    = mask_q;
      err_d    = err_q | (|(req & chk_q));
      if (state_q == IDLE) begin
         if (pick_vld) begin
            state_d  = BURST;
            owner_d  = pick_id;
            rr_ptr_d = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            rem_d    = cnt;
            busy_d   = 1'b1;
            gnt_d    = (cnt != '0) ? win_oh : '0;
            last_d   = (cnt <= CNT_W'(1)) ? win_oh : '0;
         end
      end else if (|last_q) begin
         state_d = IDLE;
         gnt_d   = '0;
         last_d  = '0;
         busy_d  = 1'b0;
         mask_d  = own_oh;
      end else begin
         rem_d  = rem_q - 1'b1;
         last_d = (rem_d == CNT_W'(1)) ? own_oh : '0;
         err_d  = err_d | ~req[owner_q];
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         rem_q    <= '0;
         gnt_q    <= '0;
         last_q   <= '0;
         busy_q   <= 1'b0;
         mask_q   <= '0;
         chk_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         rem_q    <= rem_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         mask_q   <= mask_d;
         chk_q    <= chk_d;
         err_q    <= err_d;
      end

   assign gnt   = gnt_q;
   assign last  = last_q;
   assign busy  = busy_q;
   assign owner = owner_q;
   assign err   = err_q;
endmodule

// File: tb/tb_burst_grant_arb.sv
// tb_burst_grant_arb: directed bench with a timeline model of bursts checked every cycle plus literal expectations.
module tb_burst_grant_arb;
   localparam int N  = 4;
   localparam int CW = 3;
   localparam int IW = 2;

   logic          clk, reset_n;
   logic [N-1:0]  req, gnt, last;
   logic [N*CW-1:0] ng;
   logic          busy, err;
   logic [IW-1:0] owner;

   int n_chk = 0, n_fail = 0;
   int edge_n = -1;

   burst_grant_arb #(.NUM_REQ(N), .CNT_W(CW), .ID_W(IW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .num_grants(ng),
      .gnt(gnt), .last(last), .busy(busy), .owner(owner), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
      end
   endfunction

   // model: each burst is a window of edges (e_win, e_last]; arbitration only after e_last
   int e_win, e_last, m_cnt, m_own, m_ptr, d_own, d_last, c;
   logic m_err, found;
   logic [N-1:0] el, x_gnt, x_last;
   logic x_busy;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_n = -1; e_win = -100; e_last = -100; m_cnt = 0; m_own = 0; m_ptr = 0;
         d_own = 0; d_last = -100; m_err = 1'b0;
         x_gnt = '0; x_last = '0; x_busy = 1'b0;
      end else begin
         edge_n++;
         if (edge_n == e_last) begin d_own = m_own; d_last = e_last; end
         if (edge_n > e_win && edge_n < e_last && !req[IW'(m_own)]) m_err = 1'b1;
         if (edge_n == d_last + 2 && req[IW'(d_own)]) m_err = 1'b1;
         if (edge_n > e_last) begin
            el = req;
            if (edge_n == d_last + 1) el[IW'(d_own)] = 1'b0;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
               c = (m_ptr + i) % N;
               if (!found && el[IW'(c)]) begin
                  found  = 1'b1;
                  m_cnt  = int'(ng[c*CW +: CW]);
                  m_own  = c;
                  e_win  = edge_n;
                  e_last = edge_n + ((m_cnt == 0) ? 1 : m_cnt);
                  m_ptr  = (c + 1) % N;
               end
            end
         end
         x_gnt = '0; x_last = '0;
         if (edge_n + 1 > e_win && edge_n + 1 <= e_win + m_cnt) x_gnt[IW'(m_own)] = 1'b1;
         if (edge_n + 1 == e_last) x_last[IW'(m_own)] = 1'b1;
         x_busy = (edge_n + 1 > e_win) && (edge_n + 1 <= e_last);
      end
   end

   always @(negedge clk)
      if (reset_n === 1'b1) begin
         chk("m_gnt", gnt, x_gnt);
         chk("m_last", last, x_last);
         chk("m_busy", busy, x_busy);
         chk("m_owner", owner, m_own);
         chk("m_err", err, m_err);
      end

   task automatic upto(int k);
      while (edge_n < k - 1) @(negedge clk);
   endtask

   task automatic setng(int i, int v);
      ng[i*CW +: CW] = CW'(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; req = '0; ng = '0;
      #1;
      chk("rst_gnt", gnt, 0); chk("rst_last", last, 0); chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0); chk("rst_err", err, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; req = '0; ng = '0;
      do_reset();
      // single requester, cnt=2
      setng(0, 2); req = 4'b0001;
      upto(1); chk("t1_gnt1", gnt, 4'b0001); chk("t1_last1", last, 0);
      upto(2); chk("t1_gnt2", gnt, 4'b0001); chk("t1_last2", last, 4'b0001);
      upto(3); chk("t1_busy3", busy, 0); chk("t1_gnt3", gnt, 0);
      upto(4); req = '0;
      upto(5); chk("t1_err", err, 0);
      // contention, both cnt=2
      do_reset();
      setng(0, 2); setng(1, 2); req = 4'b0011;
      upto(1); chk("t2_gnt1", gnt, 4'b0001);
      upto(3); chk("t2_gap", gnt, 0);
      upto(4); req[0] = 1'b0; chk("t2_gnt4", gnt, 4'b0010);
      upto(5); chk("t2_last5", last, 4'b0010); chk("t2_owner", owner, 1);
      upto(7); req[1] = 1'b0;
      upto(8); chk("t2_err", err, 0);
      // fairness, all cnt=1
      do_reset();
      for (int i = 0; i < N; i++) setng(i, 1);
      for (int k = 0; k <= 10; k++) begin
         upto(k);
         for (int i = 0; i < N; i++) req[i] = (k < 10) && (k != 2*i + 3);
         if (k >= 1) chk("t3_order", gnt, (k % 2 == 1) ? (1 << (((k - 1) / 2) % 4)) : 0);
      end
      upto(11); chk("t3_err", err, 0);
      // cnt=0 then cnt=7
      do_reset();
      setng(2, 0); req = 4'b0100;
      upto(1); chk("t4_last0", last, 4'b0100); chk("t4_gnt0", gnt, 0);
      upto(2); chk("t4_idle", last | gnt, 0);
      upto(3); req = '0;
      upto(4); setng(3, 7); req = 4'b1000;
      for (int k = 5; k <= 12; k++) begin
         upto(k);
         chk("t4_gnt7", gnt, (k <= 11) ? 4'b1000 : 0);
         chk("t4_last7", last, (k == 11) ? 4'b1000 : 0);
      end
      upto(13); req = '0;
      upto(14); chk("t4_err", err, 0);
      // owner drops req early in a cnt=3 burst
      do_reset();
      setng(1, 3); req = 4'b0010;
      upto(2); req = '0; chk("t5_gnt2", gnt, 4'b0010);
      upto(3); chk("t5_gnt3", gnt, 4'b0010); chk("t5_last3", last, 4'b0010); chk("t5_err3", err, 1);
      upto(6); chk("t5_sticky", err, 1);
      // owner holds req at L+2
      do_reset();
      setng(0, 1); req = 4'b0001;
      upto(3); chk("t6_err_pre", err, 0);
      upto(4); chk("t6_err", err, 1); chk("t6_regnt", gnt, 4'b0001);
      upto(5); req = '0;
      // mid-burst reset
      do_reset();
      setng(3, 5); req = 4'b1000;
      upto(2); chk("t7_gnt_pre", gnt, 4'b1000);
      #1 reset_n = 1'b0;
      #1 chk("t7_gnt_async", gnt, 0); chk("t7_busy_async", busy, 0);
      @(negedge clk); req = 4'b0101; ng = '0; setng(0, 1); setng(2, 1);
      @(negedge clk); reset_n = 1'b1;
      upto(1); chk("t7_first", gnt, 4'b0001); chk("t7_owner0", owner, 0);
      upto(3); req[0] = 1'b0; chk("t7_second", gnt, 4'b0100); chk("t7_owner2", owner, 2);
      upto(5); req = '0;
      upto(6); chk("t7_err", err, 0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
